// File: rtl/dmem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge_pkg
// Brief    : Shared access-size / FSM-state types and lane helpers for dmem_bridge
// Revision : 1.0 - initial release
// ============================================================================
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    localparam int unsigned TCNT_W = 16;

    // Encoding 3 is not a legal size and behaves as a full word.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            MEM_B:   return 4'b0001;
            MEM_H:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_B:   return 1'b0;
            MEM_H:   return off[0];
            default: return (off != 2'd0);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bridge_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge_lane_align
// Brief    : Combinational byte-lane steering between core data and word bus
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bridge_lane_align (
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    import dmem_bridge_pkg::*;

    logic [4:0]  shamt;
    logic [31:0] rshift;

    assign shamt   = {off_i, 3'b000};
    // Lanes shifted past byte 3 fall off the top and are simply not enabled.
    assign be_o    = size_mask(size_i) << off_i;
    assign wdata_o = wdata_i << shamt;
    assign rshift  = rdata_i >> shamt;

    always_comb begin
        case (size_i)
            MEM_B:   rdata_o = {24'h0, rshift[7:0]};
            MEM_H:   rdata_o = {16'h0, rshift[15:0]};
            default: rdata_o = rshift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge
// Brief    : Core data port to valid/ready bus bridge with stall, error and
//            timeout handling. Define DMEM_MISALIGN_TRAP_EN to trap misaligned
//            half/word accesses instead of issuing them.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_rd_req,
    input  logic [3:0]  c_we,
    input  logic [1:0]  c_size,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wr_data,
    output logic [31:0] c_rd_data,
    output logic        stall,
    output logic        fault,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    input  logic        m_err
);
    import dmem_bridge_pkg::*;

    localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_t       state_q, state_d;
    logic [TCNT_W-1:0] cnt_q, cnt_d;
    logic              fault_q, fault_d;
    logic [31:0]       rd_data_q, rd_data_d;

    logic        is_store;
    logic        request;
    logic        tmo_hit;
    logic        misalign_trap;
    logic [31:0] rdata_ex;

    assign is_store = |c_we;
    assign request  = c_rd_req | is_store;
    assign tmo_hit  = (cnt_q == TMO_LAST);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_trap = misaligned(c_size, c_addr[1:0]);
`else
    assign misalign_trap = 1'b0;
`endif

    dmem_bridge_lane_align u_lane_align (
        .size_i  (c_size),
        .off_i   (c_addr[1:0]),
        .wdata_i (c_wr_data),
        .rdata_i (m_rdata),
        .be_o    (m_be),
        .wdata_o (m_wdata),
        .rdata_o (rdata_ex)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fault_d   = 1'b0;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (request) begin
                    if (misalign_trap) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                cnt_d = cnt_q + 1'b1;
                if (m_ready) begin
                    state_d = RESP;
                end else if (tmo_hit) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    if (!is_store) rd_data_d = '0;
                end
            end
            RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (m_rvalid) begin
                    state_d = DONE;
                    fault_d = m_err;
                    if (!is_store) rd_data_d = m_err ? 32'h0 : rdata_ex;
                end else if (tmo_hit) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    if (!is_store) rd_data_d = '0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
            rd_data_q <= rd_data_d;
        end
    end

    // The core releases on DONE, so stall is low there even if a request is still present.
    assign stall     = ((state_q == IDLE) & request) | (state_q == ADDR) | (state_q == RESP);
    assign m_valid   = (state_q == ADDR);
    assign m_addr    = {c_addr[31:2], 2'b00};
    assign m_we      = is_store;
    assign fault     = fault_q;
    assign c_rd_data = rd_data_q;

endmodule
`default_nettype wire
